// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data_mem_responder slice: FSM state encoding,
// word/byte-enable widths, byte-lane merge and the access error check.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_t;

  function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0] old_word,
                                                 input logic [WORD_W-1:0] new_word,
                                                 input logic [BE_W-1:0]   be);
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

  // Misaligned byte address or word index beyond the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for data_mem_responder: byte-enabled synchronous write,
// combinational read, whole array cleared asynchronously on reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned IDX_W       = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= be_merge(mem[idx], wdata, be);
    end
  end

  always_comb begin
    rdata = '0;
    if (32'(idx) < DEPTH_WORDS) rdata = mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Request/response data memory with programmable access latency (WAIT_CYCLES).
// Define DMEM_POSTED_WRITE_EN to post stores (no response channel beat for stores).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  dmem_state_t       state;
  logic [3:0]        cnt;
  logic              cap_write;
  logic [31:0]       cap_addr;
  logic [WORD_W-1:0] cap_wdata;
  logic [BE_W-1:0]   cap_be;

  logic              acc_write;
  logic [31:0]       acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              acc_err;
  logic              accept;
  logic              exec;
  logic              post_drop;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = (state == ST_IDLE) && req_valid;

  // With zero latency the access runs at the accepting edge, so it must use the
  // live request rather than the capture registers.
  always_comb begin
    acc_write = cap_write;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    acc_be    = cap_be;
    if (state == ST_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  assign exec    = (WAIT_CYCLES == 0) ? accept : ((state == ST_WAIT) && (cnt == 4'd1));
  assign acc_err = addr_err(acc_addr, DEPTH_WORDS);
  assign mem_we  = exec && acc_write && !acc_err;

`ifdef DMEM_POSTED_WRITE_EN
  assign post_drop = acc_write;
`else
  assign post_drop = 1'b0;
`endif

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .idx   (acc_addr[2 +: IDX_W]),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            if (WAIT_CYCLES != 0) begin
              cnt   <= WAIT_INIT;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: cnt <= cnt - 4'd1;
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (exec) begin
        if (post_drop) begin
          state <= ST_IDLE;
        end else begin
          state     <= ST_RESP;
          rsp_err   <= acc_err;
          rsp_rdata <= (!acc_write && !acc_err) ? mem_rdata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a byte-addressed reference memory.
// Honours DMEM_POSTED_WRITE_EN when the design is built with it.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned WAITC = 2;
  localparam int unsigned MEM_BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_write;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  logic [7:0]  ref_bytes [MEM_BYTES];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < int'(MEM_BYTES); i++) ref_bytes[i] = 8'h00;
  endtask

  // Drives one request at a negedge and runs it to completion; returns at a negedge.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int unsigned hold,
                        output logic [31:0] got_rd, output logic got_err);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          n;
    logic        seen;
    exp_err = (a[1:0] != 2'b00) || (a >= MEM_BYTES);
    exp_rd  = 32'h0;
    if (!exp_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w && be[i]) ref_bytes[a + 32'(i)] = d[8*i +: 8];
        if (!w) exp_rd[8*i +: 8] = ref_bytes[a + 32'(i)];
      end
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    check_eq("req_ready_before", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_be = 4'($urandom); rsp_ready = 1'($urandom);
    n = 0; seen = 1'b0; got_rd = 32'h0; got_err = 1'b0;
`ifdef DMEM_POSTED_WRITE_EN
    if (w) begin
      do begin @(negedge clk); n++; if (rsp_valid) seen = 1'b1; end
      while (!req_ready && n < 40);
      check_eq("posted_ready_latency", 32'(n), 32'(WAITC + 1));
      check_eq("posted_no_rsp", 32'(seen), 32'd0);
    end else begin
`else
    begin
`endif
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
      check_eq("rsp_latency", 32'(n), 32'(WAITC + 1));
      check_eq("rsp_rdata", rsp_rdata, exp_rd);
      check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
      check_eq("req_ready_busy", 32'(req_ready), 32'd0);
      got_rd = rsp_rdata; got_err = rsp_err;
      rsp_ready = (hold == 0);
      repeat (hold) begin
        @(negedge clk);
        check_eq("hold_valid", 32'(rsp_valid), 32'd1);
        check_eq("hold_rdata", rsp_rdata, exp_rd);
        check_eq("hold_err", 32'(rsp_err), 32'(exp_err));
        check_eq("hold_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check_eq("idle_valid", 32'(rsp_valid), 32'd0);
      check_eq("idle_req_ready", 32'(req_ready), 32'd1);
      check_eq("idle_rdata", rsp_rdata, 32'h0);
      check_eq("idle_err", 32'(rsp_err), 32'd0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    int          n;
    reset = 1'b1; rsp_ready = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    b_rsp_ready = 1'b1;
    ref_clear();
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'h0);
    check_eq("rst_err", 32'(rsp_err), 32'd0);
    check_eq("rst0_req_ready", 32'(b_req_ready), 32'd1);
    check_eq("rst0_rsp_valid", 32'(b_rsp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full word store, then read back; partial byte-lane store over it.
    do_req(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 0, rd, er);
    do_req(1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er);
    check_eq("t1_load", rd, 32'hDEADBEEF);
    do_req(1'b1, 32'h8, 32'h11223344, 4'b0101, 1, rd, er);
    do_req(1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er);
    check_eq("t2_merge", rd, 32'hDE22BE44);

    // Misaligned load and out-of-range store, then scan the whole array.
    do_req(1'b0, 32'h6, 32'h0, 4'h0, 0, rd, er);
    check_eq("t3_mis_err", 32'(er), 32'd1);
    check_eq("t3_mis_rdata", rd, 32'h0);
    do_req(1'b1, 32'h200, 32'hFFFFFFFF, 4'hF, 0, rd, er);
`ifndef DMEM_POSTED_WRITE_EN
    check_eq("t3_oor_err", 32'(er), 32'd1);
`endif
    for (int i = 0; i < int'(DEPTH); i++) do_req(1'b0, 32'(i * 4), 32'h0, 4'h0, 0, rd, er);

    // Backpressure with a request waiting; it must not be taken until IDLE.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8; req_be = 4'h0;
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0; n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 40);
    check_eq("t4_latency", 32'(n), 32'(WAITC + 1));
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'hC; req_wdata = 32'hA5A5A5A5; req_be = 4'hF;
    repeat (5) begin
      @(negedge clk);
      check_eq("t4_valid", 32'(rsp_valid), 32'd1);
      check_eq("t4_rdata", rsp_rdata, 32'hDE22BE44);
      check_eq("t4_err", 32'(rsp_err), 32'd0);
      check_eq("t4_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_eq("t4_idle_ready", 32'(req_ready), 32'd1);
    check_eq("t4_idle_valid", 32'(rsp_valid), 32'd0);
    do_req(1'b1, 32'hC, 32'hA5A5A5A5, 4'hF, 0, rd, er);
    do_req(1'b0, 32'hC, 32'h0, 4'h0, 0, rd, er);

    // Reset while a store is still waiting: it must never land.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'h5; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("t5_req_ready", 32'(req_ready), 32'd1);
    check_eq("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    ref_clear();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("t5_no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_req(1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er);
    check_eq("t5_load", rd, 32'h0);

    // Randomised traffic against the byte model.
    for (int t = 0; t < 300; t++) begin
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 1) a = MEM_BYTES + (32'($urandom_range(0, 1000)) << 2);
      else               a = 32'($urandom_range(0, 15)) << 2;
      do_req(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), rd, er);
    end

    // Zero-latency instance.
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h10; b_req_wdata = 32'hCAFEF00D; b_req_be = 4'hF;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
`ifdef DMEM_POSTED_WRITE_EN
    check_eq("w0_posted_valid", 32'(b_rsp_valid), 32'd0);
    check_eq("w0_posted_ready", 32'(b_req_ready), 32'd1);
`else
    check_eq("w0_store_valid", 32'(b_rsp_valid), 32'd1);
    check_eq("w0_store_err", 32'(b_rsp_err), 32'd0);
    check_eq("w0_store_rdata", b_rsp_rdata, 32'h0);
    @(negedge clk);
    check_eq("w0_store_idle", 32'(b_req_ready), 32'd1);
`endif
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h10;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    check_eq("w0_load_valid", 32'(b_rsp_valid), 32'd1);
    check_eq("w0_load_rdata", b_rsp_rdata, 32'hCAFEF00D);
    check_eq("w0_load_err", 32'(b_rsp_err), 32'd0);
    @(negedge clk);
    check_eq("w0_load_idle", 32'(b_rsp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Word-organised data memory that acts as the responder end of a request/response memory interface.
- The datapath, or a later multi-cycle/pipelined core, is the initiator.
- Accepts one read or write request at a time, applies a programmable access latency, and returns read data and an error flag on a separate response channel.
- Replaces the zero-latency combinational data memory once cores are built with stall handling.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words; word index = req_addr[31:2].
- WAIT_CYCLES, 2, extra cycles between request acceptance and response; legal range 0..15.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; be[i] selects bits [8i+7:8i].
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (async): state IDLE, latency counter 0, capture registers 0, all memory words 0. Output reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted when req_valid and req_ready are both 1 at a clock edge (E0). The edge captures write, addr, wdata and be.
  - If WAIT_CYCLES=0: at E0 the access executes and the state goes to RESP.
  - Otherwise: the counter loads WAIT_CYCLES and the state goes to WAIT.
- WAIT:
  - req_ready=0.
  - Each edge decrements the counter.
  - On the edge where the counter equals 1, the access executes and the state goes to RESP.
  - rsp_valid therefore first rises in the cycle after edge E0+WAIT_CYCLES.
- Access execution:
  - Error if addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS. An error access leaves memory unmodified, rsp_err=1, rsp_rdata=0.
  - Load: rsp_rdata is registered as mem[idx], full word; be is ignored.
  - Store: only the byte lanes with be set are updated; be=0 is a legal no-op store. rsp_rdata=0.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1 at an edge.
  - On that edge: go to IDLE, rsp_valid=0, rsp_rdata and rsp_err cleared to 0.
  - req_ready=0 throughout RESP.
- Single outstanding request. Minimum spacing between accepted requests is WAIT_CYCLES+2 cycles when rsp_ready is tied high.
- req_* inputs are sampled only at the accepting edge; later changes to them have no effect.
- rsp_ready while rsp_valid=0 is ignored.
- Reset asserted mid-transaction aborts it: a pending store is not applied if it has not executed yet, no response is issued, and the state returns to IDLE.

Optional Feature:
- Macro DMEM_POSTED_WRITE_EN.
- Defined: stores are posted. After a store executes, the FSM goes directly to IDLE with no response; rsp_valid never asserts for a store, including erroring stores (their error is dropped). Loads are unchanged.
- Undefined: every store produces a response as described above (rdata=0, err as computed).

Decomposition:
- Shared package dmem_pkg contains:
  - FSM state enum (IDLE, WAIT, RESP).
  - WORD_W=32, BE_W=4.
  - Function for the byte-lane merge (old word, new word, be) -> merged word.
  - Function for the alignment/range error check.
- Sub-module dmem_array: storage plus byte-enabled synchronous write, combinational read, and async clear on reset. The FSM and latency counter live in the top module.

Test Plan:
1. Reset, then store addr=0x8, wdata=0xDEADBEEF, be=4'hF; with rsp_ready=1, rsp_valid rises 2 cycles after acceptance (WAIT_CYCLES=2) with err=0. A following load of 0x8 returns 0xDEADBEEF.
2. Store addr=0x8, wdata=0x11223344, be=4'b0101 over the previous word; a load of 0x8 returns 0xDE22BE44.
3. Load addr=0x6 returns err=1, rdata=0. Store to addr=0x200 (word 128, DEPTH_WORDS=128) returns err=1, and a load of every word shows no modification.
4. Backpressure: load completes, then rsp_ready is held 0 for 5 cycles. rsp_valid, rdata and err stay stable, req_ready stays 0, and a request presented meanwhile is not accepted. Raising rsp_ready gives IDLE on the next edge, and the waiting request is accepted on the following edge.
5. Reset asserted during WAIT of a store to 0x4 with wdata=0x5: rsp_valid stays 0, a load of 0x4 after reset returns 0, and req_ready=1 immediately on reset assertion.
6. WAIT_CYCLES=0 build: load is accepted at E0 and rsp_valid=1 in the cycle after E0. With DMEM_POSTED_WRITE_EN defined, a store gives no rsp_valid and req_ready returns high one cycle after acceptance.
